div_unit_r32i: RTL and testbench

//  Multi-cycle RV32M divide/remainder unit in the execute stage, alongside the combinational ALU.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_unit_r32i_step.sv | 26 ++
 rtl/div_unit_r32i.sv | 159 +++++++++++++++
 tb/tb_div_unit_r32i.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divide/remainder unit.
package div_pkg;

    // op[1] selects the remainder, op[0] selects unsigned operation.
    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Native datapath width of the unit.
    localparam int DIV_XLEN = 32;

    // Corner-case results: divide by zero yields an all-ones quotient;
    // signed overflow (most negative / -1) yields the most negative quotient
    // and a zero remainder.
    localparam logic [DIV_XLEN-1:0] DIV0_QUO = '1;
    localparam logic [DIV_XLEN-1:0] OVF_QUO  = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_XLEN-1:0] OVF_REM  = '0;

endpackage

// File: rtl/div_unit_r32i_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor from the widened partial remainder, keep the difference when there
// is no borrow and shift the resulting quotient bit in at quo[0].
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted;
    logic       no_borrow;

    // Trial subtraction. The true difference is always below 2^W, so the
    // W-bit modular subtraction gives the exact new remainder.
    always_comb begin
        shifted   = {rem_in, quo_in[W-1]};
        no_borrow = (shifted >= {1'b0, divisor});
        rem_out   = no_borrow ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
        quo_out   = {quo_in[W-2:0], no_borrow};
    end

endmodule

// File: rtl/div_unit_r32i.sv
// RV32M multi-cycle divide/remainder unit (DIV/DIVU/REM/REMU).
// Radix-2 restoring divider, one quotient bit per clock, start/ready/done handshake.
//
// Handshake: a request is accepted on a rising edge where start=1, ready=1 and
// flush=0; ready is high only while idle and a start while busy is dropped.
// done pulses for exactly one cycle with result valid; result then holds until
// the next completed operation overwrites it.
//
// Optional build macro DIV_FASTPATH_EN: divide-by-zero and signed-overflow
// requests skip the iterations and complete straight from the accepting edge.
module div_unit_r32i
    import div_pkg::*;
#(
    parameter int dataW = DIV_XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [dataW-1:0] result
);

    localparam int CNT_W = $clog2(dataW) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(dataW - 1);

    // Corner-case constants resized to the configured width.
    localparam logic [dataW-1:0] QUO_DIV0 = {dataW{DIV0_QUO[0]}};
    localparam logic [dataW-1:0] QUO_OVF  = {OVF_QUO[DIV_XLEN-1], {(dataW-1){1'b0}}};
    localparam logic [dataW-1:0] REM_OVF  = {dataW{OVF_REM[0]}};
    localparam logic [dataW-1:0] ALL_ONES = {dataW{1'b1}};

    div_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [dataW-1:0] rem_q, quo_q, dvsr_q;
    div_op_t          op_q;
    logic             neg_quo_q, neg_rem_q, bzero_q, ovf_q;

    logic             accept, last_iter;
    logic             in_signed, a_neg, b_neg, in_bzero, in_ovf;
    logic [dataW-1:0] a_abs, b_abs;
    logic [dataW-1:0] step_rem, step_quo;
    logic [dataW-1:0] fix_quo, fix_rem, final_val;

    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign accept    = start & ready & ~flush;
    assign last_iter = (cnt == LAST_ITER);

    // Operand conditioning: magnitudes, result signs and corner-case detection.
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & A[dataW-1];
        b_neg     = in_signed & B[dataW-1];
        a_abs     = a_neg ? (~A + 1'b1) : A;
        b_abs     = b_neg ? (~B + 1'b1) : B;
        in_bzero  = (B == '0);
        in_ovf    = in_signed & (A == QUO_OVF) & (B == ALL_ONES);
    end

    div_step #(.W(dataW)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Final sign fixup; corner cases override the raw iteration result.
    always_comb begin
        fix_quo = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        fix_rem = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        if (bzero_q) begin
            fix_quo = QUO_DIV0;
        end else if (ovf_q) begin
            fix_quo = QUO_OVF;
            fix_rem = REM_OVF;
        end
        final_val = op_q[1] ? fix_rem : fix_quo;
    end

`ifdef DIV_FASTPATH_EN
    logic [dataW-1:0] corner_val;
    logic             corner_in;

    // Direct result for requests that need no iterations.
    always_comb begin
        corner_in  = in_bzero | in_ovf;
        corner_val = op[1] ? (in_bzero ? A : REM_OVF)
                           : (in_bzero ? QUO_DIV0 : QUO_OVF);
    end
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; flush returns to IDLE from anywhere and beats start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_FASTPATH_EN
                    next_state = corner_in ? DONE : BUSY;
`else
                    next_state = BUSY;
`endif
                end
            end
            BUSY:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Datapath: operand capture on accept, one iteration per BUSY edge,
    // result load on the edge entering DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            op_q      <= DIV_S;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvsr_q    <= b_abs;
            op_q      <= div_op_t'(op);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= in_bzero;
            ovf_q     <= in_ovf;
`ifdef DIV_FASTPATH_EN
            if (corner_in) result <= corner_val;
`endif
        end else if ((state == BUSY) && !flush) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + 1'b1;
            if (last_iter) result <= final_val;
        end
    end

endmodule

// File: tb/tb_div_unit_r32i.sv
// Directed self-checking bench for div_unit_r32i.
module tb_div_unit_r32i;

    logic        clock;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIV_FASTPATH_EN
    // Corner cases finish at the accepting edge: done is seen right after it.
    localparam int CORNER_LAT = 0;
`else
    localparam int CORNER_LAT = 32;
`endif

    div_unit_r32i #(.dataW(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done. lat counts rising edges
    // after the accepting edge until done is observed. pulse_at >= 0 drives a
    // spurious start with different operands during that cycle of the run.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, output logic [31:0] res, output int lat,
                         output logic rdy_err);
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        rdy_err = 1'b0;
        while (!done && lat < 100) begin
            if (ready) rdy_err = 1'b1;
            if (lat == pulse_at) begin
                start = 1'b1; op = 2'b01; A = 32'd99; B = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                            input int pulse_at);
        logic [31:0] res;
        int          lat;
        logic        rdy_err;
        do_op(o, a, b, pulse_at, res, lat, rdy_err);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " ready low while busy"}, {31'b0, rdy_err}, 32'd0);
        @(negedge clock);
        check({tag, " done single cycle"}, {31'b0, done}, 32'd0);
        check({tag, " ready after done"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        logic seen_done;

        // Reset
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset ready", {31'b0, ready}, 32'd1);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Main function
        op_check("DIV 18/4",        2'b00, 32'd18,        32'd4,         32'd4,         32, -1);
        op_check("REM 18/-4",       2'b10, 32'd18,        32'hFFFFFFFC,  32'd2,         32, -1);
        op_check("DIV 18/-4",       2'b00, 32'd18,        32'hFFFFFFFC,  32'hFFFFFFFC,  32, -1);
        op_check("REM -18/4",       2'b10, 32'hFFFFFFEE,  32'd4,         32'hFFFFFFFE,  32, -1);
        op_check("DIV -18/-4",      2'b00, 32'hFFFFFFEE,  32'hFFFFFFFC,  32'd4,         32, -1);
        op_check("DIVU FFFFFFFE/2", 2'b01, 32'hFFFFFFFE,  32'd2,         32'h7FFFFFFF,  32, -1);
        op_check("REMU FFFFFFFF/10",2'b11, 32'hFFFFFFFF,  32'h10,        32'hF,         32, -1);

        // Corner cases
        op_check("DIV 7/0",         2'b00, 32'd7,         32'd0,         32'hFFFFFFFF,  CORNER_LAT, -1);
        op_check("REM 7/0",         2'b10, 32'd7,         32'd0,         32'd7,         CORNER_LAT, -1);
        op_check("DIV -7/0",        2'b00, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  CORNER_LAT, -1);
        op_check("DIVU 5/0",        2'b01, 32'd5,         32'd0,         32'hFFFFFFFF,  CORNER_LAT, -1);
        op_check("REMU 5/0",        2'b11, 32'd5,         32'd0,         32'd5,         CORNER_LAT, -1);
        op_check("DIV ovf",         2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  CORNER_LAT, -1);
        op_check("REM ovf",         2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         CORNER_LAT, -1);
        op_check("REM -7/0",        2'b10, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  CORNER_LAT, -1);

        // Flush mid-operation: no done, result keeps the previous value
        @(negedge clock);
        start = 1'b1; op = 2'b00; A = 32'd100; B = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        check("flush ready", {31'b0, ready}, 32'd1);
        check("flush done", {31'b0, done}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) seen_done = 1'b1;
        end
        check("flush no done", {31'b0, seen_done}, 32'd0);
        check("flush result held", result, 32'hFFFFFFF9);

        // Flush together with start: start dropped
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = 2'b00; A = 32'd9; B = 32'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush+start ready", {31'b0, ready}, 32'd1);

        op_check("DIV 100/7",       2'b00, 32'd100,       32'd7,         32'd14,        32, -1);

        // Start pulse while busy is ignored
        op_check("DIV 18/4 pulse",  2'b00, 32'd18,        32'd4,         32'd4,         32, 5);

        // Asynchronous reset during a busy operation
        @(negedge clock);
        start = 1'b1; op = 2'b00; A = 32'd100; B = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async reset ready", {31'b0, ready}, 32'd1);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("post reset result", result, 32'd0);

        op_check("REMU 100/7",      2'b11, 32'd100,       32'd7,         32'd2,         32, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
